// File: rtl/led_scanner_pkg.sv
// Shared encodings for the LED scanner family: run modes, scan direction,
// head FSM states and the position-width helper.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_WRAP_R = 2'b01,
        MODE_WRAP_L = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        HS_RUN   = 1'b0,
        HS_DWELL = 1'b1
    } head_state_e;

    function automatic int POS_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/led_scanner_if.sv
// Control and LED-drive bundle between a register block / switch bank and
// the scanner.
interface led_scanner_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 26
);
    import led_scanner_pkg::*;

    localparam int PW = POS_W(WIDTH);

    // en/mode/period are level controls sampled every cycle; there is no
    // back-pressure. tick is high for exactly the cycle in which led, pos, dir
    // and state first show a new value, and low in every other cycle.
    logic             en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic [WIDTH-1:0] led;
    logic [PW-1:0]    pos;
    logic             dir;
    logic             tick;
    head_state_e      state;

    modport master (output en, mode, period, input led, pos, dir, tick, state);
    modport slave  (input en, mode, period, output led, pos, dir, tick, state);

endinterface

// File: rtl/tick_prescaler.sv
// Programmable strobe generator: with en held high, stb fires once every
// period+1 cycles.
module tick_prescaler #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             stb
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // ">=" lets a period lowered below the running count fire immediately
    assign stb = en && (cnt >= period);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (stb) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/led_scanner.sv
// Parametrised LED scanner: moves a lit head with optional fading tail across
// WIDTH LEDs in bounce, wrap or hold modes at a programmable tick rate.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_W     = 26,
    parameter int TAIL      = 0,
    parameter int END_DWELL = 0
) (
    input  logic          clk,
    input  logic          rst,
    led_scanner_if.slave  io
);

    localparam int              PW         = POS_W(WIDTH);
    localparam logic [PW-1:0]   POS_MAX    = PW'(WIDTH - 1);
    localparam logic [PW-1:0]   POS_ONE    = PW'(1);
    localparam logic [3:0]      DWELL_INIT = 4'(END_DWELL);
    localparam logic [WIDTH-1:0] LED_ONE   = WIDTH'(1);

    function automatic logic [WIDTH-1:0] onehot(input logic [PW-1:0] p);
        return LED_ONE << p;
    endfunction

    logic              stb;
    logic [PW-1:0]     pos_q, pos_n, moved;
    logic              dir_q, dir_n, eff_dir;
    logic [3:0]        dwell_q, dwell_n;
    logic [WIDTH-1:0]  led_q, tail_n;
    logic              tick_q;
    head_state_e       state_q;

    tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (io.en),
        .period (io.period),
        .stb    (stb)
    );

    // Next head position/direction; only committed on stb.
    always_comb begin
        pos_n   = pos_q;
        dir_n   = dir_q;
        dwell_n = dwell_q;
        // At an end the head always moves inward, which also repairs an
        // outward dir left behind by a wrap mode.
        eff_dir = dir_q;
        if (pos_q == '0) begin
            eff_dir = DIR_LEFT;
        end else if (pos_q == POS_MAX) begin
            eff_dir = DIR_RIGHT;
        end
        moved = (eff_dir == DIR_LEFT) ? pos_q + POS_ONE : pos_q - POS_ONE;

        case (mode_e'(io.mode))
            MODE_BOUNCE: begin
                if (dwell_q != 4'd0) begin
                    dwell_n = dwell_q - 4'd1;
                end else begin
                    pos_n = moved;
                    dir_n = eff_dir;
                    if (moved == '0 || moved == POS_MAX) begin
                        dir_n   = ~eff_dir;
                        dwell_n = DWELL_INIT;
                    end
                end
            end
            MODE_WRAP_R: begin
                dir_n   = DIR_RIGHT;
                pos_n   = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
                dwell_n = 4'd0;
            end
            MODE_WRAP_L: begin
                dir_n   = DIR_LEFT;
                pos_n   = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
                dwell_n = 4'd0;
            end
            default: begin
                dwell_n = 4'd0;
            end
        endcase
    end

    // The oldest trail position is only ever needed in led itself, so just
    // TAIL-1 positions are stored; the outgoing head is the newest entry.
    if (TAIL == 0) begin : g_no_tail
        assign tail_n = '0;
    end else if (TAIL == 1) begin : g_tail1
        assign tail_n = onehot(pos_q);
    end else begin : g_tail
        logic [PW-1:0] hist [TAIL-1];

        always_comb begin
            tail_n = onehot(pos_q);
            for (int i = 0; i < TAIL - 1; i++) begin
                tail_n = tail_n | onehot(hist[i]);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < TAIL - 1; i++) begin
                    hist[i] <= POS_MAX;
                end
            end else if (stb) begin
                hist[0] <= pos_q;
                for (int i = 1; i < TAIL - 1; i++) begin
                    hist[i] <= hist[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q   <= POS_MAX;
            dir_q   <= DIR_RIGHT;
            dwell_q <= 4'd0;
            led_q   <= onehot(POS_MAX);
            tick_q  <= 1'b0;
            state_q <= HS_RUN;
        end else begin
            tick_q <= stb;
            if (stb) begin
                pos_q   <= pos_n;
                dir_q   <= dir_n;
                dwell_q <= dwell_n;
                led_q   <= onehot(pos_n) | tail_n;
                state_q <= (dwell_n != 4'd0) ? HS_DWELL : HS_RUN;
            end
        end
    end

    assign io.led   = led_q;
    assign io.pos   = pos_q;
    assign io.dir   = dir_q;
    assign io.tick  = tick_q;
    assign io.state = state_q;

endmodule

// File: tb/tb_led_scanner.sv
// Scoreboard bench for led_scanner: a position/queue reference model predicts
// each update, a monitor compares every cycle against it.
module tb_led_scanner;
  import led_scanner_pkg::*;

  localparam int WIDTH     = 8;
  localparam int CNT_W     = 12;
  localparam int TAIL      = 2;
  localparam int END_DWELL = 2;
  localparam int PW        = POS_W(WIDTH);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_scanner_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

  led_scanner #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .TAIL(TAIL), .END_DWELL(END_DWELL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (sif.slave)
  );

  // scoreboard
  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] led;
    logic [PW-1:0]    pos;
    logic             dir;
    logic             dwell;
  } exp_t;
  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // reference model: plain integers and a queue of past head positions
  int m_cnt   = 0;
  int m_pos   = WIDTH - 1;
  int m_dir   = 0;
  int m_dwell = 0;
  int m_hist[$];

  function automatic logic [WIDTH-1:0] model_led();
    logic [WIDTH-1:0] one = 1;
    logic [WIDTH-1:0] l;
    l = one << m_pos;
    foreach (m_hist[i]) l = l | (one << m_hist[i]);
    return l;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pos = WIDTH - 1; m_dir = 0; m_dwell = 0;
    m_hist.delete();
    for (int i = 0; i < TAIL; i++) m_hist.push_back(WIDTH - 1);
  endtask

  task automatic model_step(input logic [1:0] mode);
    int old_pos;
    int step;
    exp_t e;
    old_pos = m_pos;
    case (mode)
      2'b00: begin
        if (m_dwell > 0) begin
          m_dwell--;
        end else begin
          if (m_pos == 0) step = 1;
          else if (m_pos == WIDTH - 1) step = -1;
          else step = (m_dir == 1) ? 1 : -1;
          m_pos += step;
          if (m_pos == 0) begin
            m_dir = 1; m_dwell = END_DWELL;
          end else if (m_pos == WIDTH - 1) begin
            m_dir = 0; m_dwell = END_DWELL;
          end else begin
            m_dir = (step > 0) ? 1 : 0;
          end
        end
      end
      2'b01: begin m_dir = 0; m_pos = (m_pos + WIDTH - 1) % WIDTH; m_dwell = 0; end
      2'b10: begin m_dir = 1; m_pos = (m_pos + 1) % WIDTH; m_dwell = 0; end
      default: m_dwell = 0;
    endcase
    m_hist.push_front(old_pos);
    while (m_hist.size() > TAIL) void'(m_hist.pop_back());
    e.cyc   = cyc + 1;
    e.led   = model_led();
    e.pos   = PW'(m_pos);
    e.dir   = (m_dir != 0);
    e.dwell = (m_dwell != 0);
    exp_q.push_back(e);
  endtask

  // driver: apply inputs at the falling edge, then predict the next rising edge
  task automatic cycle_in(input logic r, input logic e, input logic [1:0] m, input int p);
    @(negedge clk);
    rst        = r;
    sif.en     = e;
    sif.mode   = m;
    sif.period = CNT_W'(p);
    if (r) begin
      model_reset();
    end else if (e) begin
      if (m_cnt >= p) begin
        m_cnt = 0;
        model_step(m);
      end else begin
        m_cnt++;
      end
    end
  endtask

  // monitor
  logic [WIDTH-1:0] last_led = 8'h80;
  exp_t got_e;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      vectors++;
      if (rst) begin
        if (sif.led !== 8'h80 || sif.pos !== PW'(WIDTH - 1) || sif.dir !== 1'b0 ||
            sif.tick !== 1'b0 || sif.state !== HS_RUN) begin
          miscompares++;
          $display("FAIL reset cyc=%0d: got led=%h pos=%0d dir=%0d tick=%0d state=%0d, want led=80 pos=%0d dir=0 tick=0 state=0",
                   cyc, sif.led, sif.pos, sif.dir, sif.tick, sif.state, WIDTH - 1);
        end
        last_led = 8'h80;
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        got_e = exp_q.pop_front();
        if (sif.tick !== 1'b1 || sif.led !== got_e.led || sif.pos !== got_e.pos ||
            sif.dir !== got_e.dir || (sif.state == HS_DWELL) !== got_e.dwell) begin
          miscompares++;
          $display("FAIL update cyc=%0d: got tick=%0d led=%h pos=%0d dir=%0d state=%0d, want tick=1 led=%h pos=%0d dir=%0d dwell=%0d",
                   cyc, sif.tick, sif.led, sif.pos, sif.dir, sif.state,
                   got_e.led, got_e.pos, got_e.dir, got_e.dwell);
        end
        last_led = got_e.led;
      end else begin
        if (sif.tick !== 1'b0 || sif.led !== last_led) begin
          miscompares++;
          $display("FAIL idle cyc=%0d: got tick=%0d led=%h, want tick=0 led=%h",
                   cyc, sif.tick, sif.led, last_led);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic       r_en;
    logic [1:0] r_mode;
    int         r_per;
    sif.en     = 1'b0;
    sif.mode   = 2'b00;
    sif.period = '0;
    model_reset();

    repeat (3)   cycle_in(1'b1, 1'b0, MODE_BOUNCE, 0);
    repeat (40)  cycle_in(1'b0, 1'b1, MODE_BOUNCE, 0);
    repeat (40)  cycle_in(1'b0, 1'b1, MODE_BOUNCE, 3);
    repeat (30)  cycle_in(1'b0, 1'b1, MODE_WRAP_R, 1);
    repeat (30)  cycle_in(1'b0, 1'b1, MODE_WRAP_L, 0);
    repeat (10)  cycle_in(1'b0, 1'b1, MODE_HOLD, 0);
    repeat (20)  cycle_in(1'b0, 1'b1, MODE_BOUNCE, 0);
    // freeze mid-count, then resume
    repeat (7)   cycle_in(1'b0, 1'b1, MODE_BOUNCE, 5);
    repeat (50)  cycle_in(1'b0, 1'b0, MODE_BOUNCE, 5);
    repeat (30)  cycle_in(1'b0, 1'b1, MODE_BOUNCE, 5);
    // long period, then drop it below the running count
    repeat (500) cycle_in(1'b0, 1'b1, MODE_BOUNCE, 1000);
    repeat (10)  cycle_in(1'b0, 1'b1, MODE_BOUNCE, 2);

    r_en = 1'b1; r_mode = MODE_BOUNCE; r_per = 0;
    for (int i = 0; i < 2000; i++) begin
      r_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) r_per = $urandom_range(0, 4);
      cycle_in(($urandom_range(0, 499) == 0), r_en, r_mode, r_per);
    end

    // reset while the head is dwelling at an end
    for (int i = 0; i < 200 && m_dwell == 0; i++) cycle_in(1'b0, 1'b1, MODE_BOUNCE, 0);
    vectors++;
    if (m_dwell == 0) begin
      miscompares++;
      $display("FAIL dwell_reach: got dwell=0 after 200 cycles, want dwell>0");
    end
    cycle_in(1'b1, 1'b1, MODE_BOUNCE, 0);
    repeat (12) cycle_in(1'b0, 1'b1, MODE_BOUNCE, 1);

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending updates, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
